// File: rtl/sw_sel_pkg.sv
// sw_sel_pkg: shared state encoding and one-hot helper for the sw_sel arbiter
package sw_sel_pkg;
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_GRANT = 2'd1;
   localparam logic [1:0] ST_GAP   = 2'd2;
   localparam int MAX_SW = 32;
   typedef enum logic [1:0] {IDLE = ST_IDLE, GRANT = ST_GRANT, GAP = ST_GAP} state_t;
   function automatic logic [MAX_SW-1:0] onehot(input int unsigned idx);
      return MAX_SW'(1) << idx;
   endfunction
endpackage

// File: rtl/sw_sel_arbiter_if.sv
// sw_sel_arbiter_if: request/grant bundle between switch instances and the arbiter
//   req         : per-instance level request (requesters -> arbiter)
//   rel         : per-instance end-of-transfer strobe ("release" is a reserved word)
//   sel         : registered one-hot grant, feeds mux_top.sel
//   grant_id    : binary index of the granted instance, valid while busy
//   busy        : a grant is held
//   timeout_err : one-cycle pulse when a grant is revoked by timeout
interface sw_sel_arbiter_if #(
   parameter int NUM_SW_INST = 5,
   parameter int ID_WIDTH    = $clog2(NUM_SW_INST)
);
   logic [NUM_SW_INST-1:0] req;
   logic [NUM_SW_INST-1:0] rel;
   logic [NUM_SW_INST-1:0] sel;
   logic [ID_WIDTH-1:0]    grant_id;
   logic                   busy;
   logic                   timeout_err;
   modport master (output req, rel, input sel, grant_id, busy, timeout_err);
   modport slave  (input req, rel, output sel, grant_id, busy, timeout_err);
endinterface

// File: rtl/rr_pick.sv
// rr_pick: combinational rotating-priority search starting just above ptr
//   req   : request vector
//   ptr   : last granted index; search begins at (ptr+1) mod NUM_SW_INST
//   found : any request present
//   idx   : first requesting index in rotated order
module rr_pick #(
   parameter int NUM_SW_INST = 5,
   parameter int ID_WIDTH    = $clog2(NUM_SW_INST)
) (
   input  logic [NUM_SW_INST-1:0] req,
   input  logic [ID_WIDTH-1:0]    ptr,
   output logic                   found,
   output logic [ID_WIDTH-1:0]    idx
);
   logic [ID_WIDTH-1:0] j;
   // scan farthest offset first so the nearest requester is assigned last and wins
   always_comb begin
      found = 1'b0;
      idx   = '0;
      j     = '0;
      for (int k = NUM_SW_INST; k >= 1; k--) begin
         j = ID_WIDTH'((int'(ptr) + k) % NUM_SW_INST);
         if (req[j]) begin
            found = 1'b1;
            idx   = j;
         end
      end
   end
endmodule

// File: rtl/sw_sel_arbiter.sv
// sw_sel_arbiter: round-robin grant generator for the mux_top read-data select
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of sw_sel_arbiter_if (req/rel in; sel/grant_id/busy/timeout_err out)
module sw_sel_arbiter
   import sw_sel_pkg::*;
#(
   parameter int NUM_SW_INST = 5,
   parameter int TIMEOUT     = 16,
   parameter int ID_WIDTH    = $clog2(NUM_SW_INST),
   parameter int CNT_WIDTH   = $clog2(TIMEOUT)
) (
   input logic             clk,
   input logic             rst_n,
   sw_sel_arbiter_if.slave bus
);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(TIMEOUT - 1);
   state_t                 state_q, state_d;
   logic [ID_WIDTH-1:0]    ptr_q, ptr_d, gid_q, gid_d, pick_idx;
   logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
   logic [NUM_SW_INST-1:0] sel_q, sel_d;
   logic                   busy_q, busy_d, tout_q, tout_d, pick_found;
   rr_pick #(.NUM_SW_INST(NUM_SW_INST), .ID_WIDTH(ID_WIDTH)) u_pick (
      .req   (bus.req),
      .ptr   (ptr_q),
      .found (pick_found),
      .idx   (pick_idx)
   );
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      sel_d   = sel_q;
      gid_d   = gid_q;
      busy_d  = busy_q;
      tout_d  = 1'b0;
      case (state_q)
         GRANT: begin
            if (bus.rel[gid_q] || !bus.req[gid_q] || cnt_q == CNT_MAX) begin
               state_d = GAP;
               sel_d   = '0;
               busy_d  = 1'b0;
               // only the pure timeout path flags an error; release wins a tie
               tout_d  = bus.req[gid_q] && !bus.rel[gid_q];
            end else begin
               cnt_d = cnt_q + CNT_WIDTH'(1);
            end
         end
         default: begin
            // IDLE and GAP arbitrate identically; the GAP cycle itself is the bus turnaround
            state_d = pick_found ? GRANT : IDLE;
            sel_d   = pick_found ? NUM_SW_INST'(onehot(32'(pick_idx))) : '0;
            busy_d  = pick_found;
            gid_d   = pick_found ? pick_idx : gid_q;
            ptr_d   = pick_found ? pick_idx : ptr_q;
            cnt_d   = pick_found ? '0 : cnt_q;
         end
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= ID_WIDTH'(NUM_SW_INST - 1);
         cnt_q   <= '0;
         sel_q   <= '0;
         gid_q   <= '0;
         busy_q  <= 1'b0;
         tout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
         gid_q   <= gid_d;
         busy_q  <= busy_d;
         tout_q  <= tout_d;
      end
   end
   assign bus.sel         = sel_q;
   assign bus.grant_id    = gid_q;
   assign bus.busy        = busy_q;
   assign bus.timeout_err = tout_q;
endmodule

// File: tb/tb_sw_sel_arbiter.sv
// tb_sw_sel_arbiter: directed scoreboard bench for sw_sel_arbiter (N=5, TIMEOUT=16)
module tb_sw_sel_arbiter;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;
   sw_sel_arbiter_if #(.NUM_SW_INST(5)) bus ();
   sw_sel_arbiter #(.NUM_SW_INST(5), .TIMEOUT(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );
   typedef struct packed {logic [4:0] sel; logic tout;} exp_t;
   exp_t sb[$];
   int total = 0;
   int bad = 0;
   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic chk_reset(input string tag);
      chk({tag, " sel"}, 8'(bus.sel), 8'h00);
      chk({tag, " busy"}, 8'(bus.busy), 8'h00);
      chk({tag, " tout"}, 8'(bus.timeout_err), 8'h00);
      chk({tag, " gid"}, 8'(bus.grant_id), 8'h00);
   endtask
   // drive one cycle of inputs, queue what the outputs must be after the edge, then check
   task automatic step(input string tag, input logic [4:0] r, l, es, input logic et);
      exp_t e;
      logic [7:0] g;
      bus.req = r;
      bus.rel = l;
      sb.push_back('{sel: es, tout: et});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk({tag, " sel"}, 8'(bus.sel), 8'(e.sel));
      chk({tag, " busy"}, 8'(bus.busy), 8'(|e.sel));
      chk({tag, " tout"}, 8'(bus.timeout_err), 8'(e.tout));
      if (e.sel != 5'b0) begin
         g = 8'h00;
         for (int i = 0; i < 5; i++) if (e.sel[i]) g = 8'(i);
         chk({tag, " gid"}, 8'(bus.grant_id), g);
      end
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end
   initial begin
      logic [4:0] g;
      bus.req = '0;
      bus.rel = '0;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk_reset("reset");
      rst_n = 1'b1;
      // all requesters active, each releasing in its third grant cycle
      for (int i = 0; i < 5; i++) begin
         g = 5'b00001 << i;
         step("rr_grant", 5'b11111, 5'b0, g, 1'b0);
         step("rr_hold1", 5'b11111, 5'b0, g, 1'b0);
         step("rr_hold2", 5'b11111, 5'b0, g, 1'b0);
         step("rr_gap", 5'b11111, g, 5'b0, 1'b0);
      end
      step("rr_wrap", 5'b11111, 5'b0, 5'b00001, 1'b0);
      step("rr_drop", 5'b00000, 5'b0, 5'b00000, 1'b0);
      step("rr_idle", 5'b00000, 5'b0, 5'b00000, 1'b0);
      // single request from idle, release for a non-granted index ignored
      step("single", 5'b00100, 5'b0, 5'b00100, 1'b0);
      step("single_wrong", 5'b00100, 5'b01000, 5'b00100, 1'b0);
      step("single_rel", 5'b00100, 5'b00100, 5'b00000, 1'b0);
      step("single_idle", 5'b00000, 5'b0, 5'b00000, 1'b0);
      // held request never released: 16 grant cycles, timeout pulse, re-grant
      step("to_grant", 5'b00010, 5'b0, 5'b00010, 1'b0);
      for (int i = 0; i < 15; i++)
         step("to_hold", 5'b00010, (i == 4) ? 5'b01000 : 5'b0, 5'b00010, 1'b0);
      step("to_expire", 5'b00010, 5'b0, 5'b00000, 1'b1);
      step("to_regrant", 5'b00010, 5'b0, 5'b00010, 1'b0);
      // release lands on the same edge as the timeout: no error
      for (int i = 0; i < 15; i++) step("tie_hold", 5'b00010, 5'b0, 5'b00010, 1'b0);
      step("tie_rel", 5'b00010, 5'b00010, 5'b00000, 1'b0);
      step("tie_idle", 5'b00000, 5'b0, 5'b00000, 1'b0);
      // async reset between edges while instance 2 holds the bus
      step("ar_grant", 5'b00100, 5'b0, 5'b00100, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset("ar_async");
      bus.req = 5'b11111;
      @(posedge clk);
      #1;
      chk_reset("ar_held");
      rst_n = 1'b1;
      step("ar_first", 5'b11111, 5'b0, 5'b00001, 1'b0);
      // requester drops req without release; pointer stays at the dropped index
      step("drop0", 5'b11110, 5'b0, 5'b00000, 1'b0);
      step("next1", 5'b11110, 5'b0, 5'b00010, 1'b0);
      step("drop1", 5'b11101, 5'b0, 5'b00000, 1'b0);
      step("next2", 5'b11101, 5'b0, 5'b00100, 1'b0);
      step("end_drop", 5'b00000, 5'b0, 5'b00000, 1'b0);
      step("end_idle", 5'b00000, 5'b0, 5'b00000, 1'b0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
